// File: rtl/dlbf_pkg.sv
// dlbf_pkg: state encodings and shared constants for the dlbf master RAM
package dlbf_pkg;
  typedef enum logic [3:0] {
    S_IDLE  = 4'h1,
    S_RUN   = 4'h2,
    S_DRAIN = 4'h4,
    S_DONE  = 4'h8
  } state_t;
  localparam int HOST_PIPE_STAGES = 4;
  localparam logic [7:0] TKEEP_ALL_ONES = 8'hFF;
endpackage

// File: rtl/dlbf_master_fifo.sv
// dlbf_master_fifo: show-ahead output buffer holding {tlast,tdata} words
module dlbf_master_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [W-1:0]                   din,
  input  logic                           pop,
  output logic [W-1:0]                   dout,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr, rd;
  // pointer and occupancy bookkeeping; push and pop may coincide
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr == PW'(DEPTH-1) ? '0 : wr + 1'b1;
      if (pop) rd <= rd == PW'(DEPTH-1) ? '0 : rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // storage is not reset; empty masks stale entries
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  assign empty = count == '0;
  assign dout  = empty ? '0 : mem[rd];
endmodule

// File: rtl/dlbf_master_ram.sv
// dlbf_master_ram: host-loaded RAM replayed niter times as an AXI4-Stream master
module dlbf_master_ram import dlbf_pkg::*; #(
  parameter int TDATA_WIDTH       = 64,
  parameter int TKEEP_WIDTH       = 8,
  parameter int URAM_DEPTH        = 8192,
  parameter int URAM_READ_LATENCY = 4,
  parameter int ADDR_WIDTH        = 16,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                   m_axis_clk,
  input  logic                   master_rst,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  input  logic                   start,
  input  logic [11:0]            niter,
  input  logic [15:0]            block_size,
  output logic                   txdone,
  output logic [3:0]             current_state_wire,
  output logic [ADDR_WIDTH-1:0]  txram_counter_wire,
  input  logic [TKEEP_WIDTH-1:0] web,
  input  logic                   enb,
  input  logic [ADDR_WIDTH-1:0]  addrb,
  input  logic [TDATA_WIDTH-1:0] dinb,
  output logic [TDATA_WIDTH-1:0] doutb
);
  localparam int RAW = $clog2(URAM_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int S   = HOST_PIPE_STAGES - 1;
  localparam int L   = URAM_READ_LATENCY;
  state_t                 state;
  logic [ADDR_WIDTH-1:0]  cnt;
  logic [11:0]            iter, niter_q;
  logic [15:0]            bs_q;
  logic                   ena, last_word;
  logic [L-1:0]           tv, tl;
  logic [HOST_PIPE_STAGES-1:0] hen;
  logic [TKEEP_WIDTH-1:0] hwe [HOST_PIPE_STAGES];
  logic [ADDR_WIDTH-1:0]  ha  [HOST_PIPE_STAGES];
  logic [TDATA_WIDTH-1:0] hd  [HOST_PIPE_STAGES];
  logic [TDATA_WIDTH-1:0] mem [URAM_DEPTH];
  logic [TDATA_WIDTH-1:0] pa  [L];
  logic [TDATA_WIDTH-1:0] pb  [L];
  logic [TDATA_WIDTH-1:0] bmask;
  logic                   b_hit;
  logic [TDATA_WIDTH:0]   fifo_dout;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  assign ena       = state == S_RUN && int'(fifo_count) + $countones(tv) < FIFO_DEPTH;
  assign last_word = cnt == bs_q - 1'b1;
  assign b_hit     = hen[S] && ha[S] < ADDR_WIDTH'(URAM_DEPTH);
  // host request valid bits are cleared by reset so no stale write lands
  always_ff @(posedge m_axis_clk or posedge master_rst)
    if (master_rst) hen <= '0;
    else hen <= {hen[HOST_PIPE_STAGES-2:0], enb};
  // host payload rides alongside the valid bits
  always_ff @(posedge m_axis_clk) begin
    hwe[0] <= web;
    ha[0]  <= addrb;
    hd[0]  <= dinb;
    for (int i = 1; i < HOST_PIPE_STAGES; i++) begin
      hwe[i] <= hwe[i-1];
      ha[i]  <= ha[i-1];
      hd[i]  <= hd[i-1];
    end
  end
  // expand byte enables into a bit mask for the port-B write
  always_comb begin
    bmask = '0;
    for (int b = 0; b < TKEEP_WIDTH; b++) bmask[b*8 +: 8] = {8{hwe[S][b]}};
  end
  // dual-port RAM: port A replay reads, port B host access in no-change mode
  always_ff @(posedge m_axis_clk) begin
    if (b_hit) mem[ha[S][RAW-1:0]] <= (mem[ha[S][RAW-1:0]] & ~bmask) | (hd[S] & bmask);
    if (b_hit && hwe[S] == '0) pb[0] <= mem[ha[S][RAW-1:0]];
    if (ena) pa[0] <= mem[cnt[RAW-1:0]];
    for (int i = 1; i < L; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  // tag pipe marks which read-pipe slots carry real words and iteration ends
  always_ff @(posedge m_axis_clk or posedge master_rst)
    if (master_rst) begin
      tv <= '0;
      tl <= '0;
    end else begin
      tv <= (tv << 1) | L'(ena);
      tl <= (tl << 1) | L'(ena && last_word);
    end
  // replay sequencer: issue reads under credit, drain, then hold done until start drops
  always_ff @(posedge m_axis_clk or posedge master_rst)
    if (master_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      iter    <= '0;
      niter_q <= '0;
      bs_q    <= '0;
      txdone  <= 1'b0;
    end else case (state)
      S_IDLE: if (start && niter != '0 && block_size != '0) begin
        state   <= S_RUN;
        niter_q <= niter;
        bs_q    <= block_size > 16'(URAM_DEPTH) ? 16'(URAM_DEPTH) : block_size;
        cnt     <= '0;
        iter    <= '0;
      end
      S_RUN: if (ena) begin
        cnt <= last_word ? '0 : cnt + 1'b1;
        if (last_word) begin
          iter <= iter + 1'b1;
          if (iter == niter_q - 1'b1) state <= S_DRAIN;
        end
      end
      S_DRAIN: if (tv == '0 && fifo_empty) begin
        state  <= S_DONE;
        txdone <= 1'b1;
      end
      S_DONE: if (!start) begin
        state  <= S_IDLE;
        txdone <= 1'b0;
      end
      default: state <= S_IDLE;
    endcase
  dlbf_master_fifo #(.W(TDATA_WIDTH+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (m_axis_clk),
    .rst   (master_rst),
    .push  (tv[L-1]),
    .din   ({tl[L-1], pa[L-1]}),
    .pop   (m_axis_tvalid && m_axis_tready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  assign m_axis_tvalid      = !fifo_empty;
  assign {m_axis_tlast, m_axis_tdata} = fifo_dout;
  assign m_axis_tkeep       = TKEEP_ALL_ONES[TKEEP_WIDTH-1:0];
  assign doutb              = pb[L-1];
  assign current_state_wire = state;
  assign txram_counter_wire = cnt;
endmodule
